// File: rtl/sig_a_toggle_gen.sv
// sig_a_toggle_gen: burst stimulus source for the single-bit sig_a.
// When start is seen in IDLE with a nonzero burst_len, the block runs a burst of burst_len
// clocks. On each of those clocks it updates sig_a from the captured mode:
//   00 Galois LFSR bit, 01 toggle, 10/11 hold.
// Optional feature: define SIG_A_CHG_CNT_EN to count the burst updates that changed sig_a.
// Without it, change_cnt is tied to zero.
// Ports:
//   clk        system clock, all state on posedge
//   rst        asynchronous active-low reset
//   start      burst request, only sampled in IDLE
//   mode       generation mode for the next accepted burst
//   burst_len  number of generated values (0 = request ignored)
//   sig_a      generated signal (registered)
//   valid      high while sig_a carries a burst-generated value
//   busy       high while running
//   done       one-cycle pulse coinciding with the last valid value
//   change_cnt number of burst updates where sig_a changed
module sig_a_toggle_gen #(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int unsigned       LEN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] burst_len,
  output logic             sig_a,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] change_cnt
);

  localparam logic [LFSR_W-1:0] Poly = 16'hB400;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_step;
  logic              sig_a_q, sig_a_next;
  logic              valid_q;
  logic              accept, run_edge;

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ Poly) : (lfsr_q >> 1);

  always_comb begin
    sig_a_next = sig_a_q;
    case (mode_q)
      2'b00:   sig_a_next = lfsr_step[0];
      2'b01:   sig_a_next = ~sig_a_q;
      default: sig_a_next = sig_a_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    run_edge = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (burst_len != '0)) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        run_edge = 1'b1;
        if (remaining_q == LEN_W'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= 2'b00;
      remaining_q <= '0;
      lfsr_q      <= SEED;
      sig_a_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q      <= mode;
        remaining_q <= burst_len;
      end
      if (run_edge) begin
        sig_a_q     <= sig_a_next;
        valid_q     <= 1'b1;
        remaining_q <= remaining_q - LEN_W'(1);
        // The LFSR only advances while generating random values; it is never reloaded mid-run.
        if (mode_q == 2'b00) lfsr_q <= lfsr_step;
      end
      // valid carries the last value through DONE and drops on the way back to IDLE.
      if (state_q == StDone) valid_q <= 1'b0;
    end
  end

`ifdef SIG_A_CHG_CNT_EN
  logic [LEN_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (run_edge && (sig_a_next != sig_a_q) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  assign change_cnt = cnt_q;
`else
  assign change_cnt = '0;
`endif

  assign sig_a = sig_a_q;
  assign valid = valid_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);

endmodule

// File: tb/tb_sig_a_toggle_gen.sv
module tb_sig_a_toggle_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] burst_len = 8'd0;
  logic       sig_a, valid, busy, done;
  logic [7:0] change_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state carried between bursts.
  logic        m_sig;
  logic [15:0] m_lfsr;
  logic [7:0]  m_cnt;

  sig_a_toggle_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .burst_len  (burst_len),
    .sig_a      (sig_a),
    .valid      (valid),
    .busy       (busy),
    .done       (done),
    .change_cnt (change_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] exp_cnt(input logic [7:0] c);
`ifdef SIG_A_CHG_CNT_EN
    return c;
`else
    return 8'd0;
`endif
  endfunction

  // One burst request. abort_at > 0 pulls reset low right after that many values.
  task automatic burst(input logic [1:0] m, input int len, input bit hold_start,
                       input int abort_at, input bit scramble);
    bit          vals[$];
    logic [7:0]  cnts[$];
    logic        prev;
    logic        v;
    logic [7:0]  c;
    logic [15:0] lf;
    @(negedge clk);
    start     = 1'b1;
    mode      = m;
    burst_len = len[7:0];
    @(posedge clk); #1;
    if (len == 0) begin
      chk("zero_len_busy", busy, 0);
      chk("zero_len_valid", valid, 0);
      chk("zero_len_done", done, 0);
      chk("zero_len_sig", sig_a, m_sig);
      chk("zero_len_cnt", change_cnt, exp_cnt(m_cnt));
      start = 1'b0;
      return;
    end
    if (!hold_start) start = 1'b0;
    // Expected value list, from the mode rules applied len times.
    prev = m_sig;
    c    = 8'd0;
    lf   = m_lfsr;
    for (int i = 0; i < len; i++) begin
      if (m == 2'b00) begin
        lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
        v  = lf[0];
      end else if (m == 2'b01) begin
        v = ~prev;
      end else begin
        v = prev;
      end
      if (v != prev && c != 8'hFF) c++;
      vals.push_back(v);
      cnts.push_back(c);
      prev = v;
    end
    chk("accept_busy", busy, 1);
    chk("accept_valid", valid, 0);
    chk("accept_sig", sig_a, m_sig);
    chk("accept_cnt", change_cnt, 0);
    for (int k = 1; k <= len; k++) begin
      if (scramble) begin
        mode      = 2'($urandom);
        burst_len = 8'($urandom);
      end
      @(posedge clk); #1;
      chk("run_sig", sig_a, vals[k-1]);
      chk("run_valid", valid, 1);
      chk("run_busy", busy, (k < len) ? 1 : 0);
      chk("run_done", done, (k == len) ? 1 : 0);
      chk("run_cnt", change_cnt, exp_cnt(cnts[k-1]));
      m_sig = vals[k-1];
      m_cnt = cnts[k-1];
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        chk("rst_sig", sig_a, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", change_cnt, 0);
        m_sig  = 1'b0;
        m_cnt  = 8'd0;
        m_lfsr = 16'hACE1;
        start  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    if (m == 2'b00) m_lfsr = lf;
    @(posedge clk); #1;
    chk("idle_valid", valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_sig", sig_a, m_sig);
    chk("idle_cnt", change_cnt, exp_cnt(m_cnt));
    start = 1'b0;
  endtask

  initial begin
    m_sig  = 1'b0;
    m_lfsr = 16'hACE1;
    m_cnt  = 8'd0;
    #12;
    chk("reset_sig", sig_a, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt", change_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    burst(2'b01, 10, 1'b0, 0, 1'b0);   // toggle, ends with sig_a = 0
    burst(2'b10, 4, 1'b0, 0, 1'b0);    // hold
    burst(2'b01, 0, 1'b0, 0, 1'b0);    // ignored request
    burst(2'b01, 20, 1'b0, 7, 1'b0);   // reset after 7 values
    burst(2'b00, 5, 1'b0, 0, 1'b0);    // seed replay 0,0,0,0,1
    chk("seed_lfsr_model", m_lfsr, 16'h0E27);
    burst(2'b01, 6, 1'b1, 0, 1'b1);    // start held through the burst
    burst(2'b11, 3, 1'b0, 0, 1'b1);    // reserved mode holds
    burst(2'b01, 255, 1'b0, 0, 1'b1);  // maximum length

    for (int n = 0; n < 40; n++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      burst(2'($urandom_range(0, 3)), len, 1'($urandom_range(0, 1)), 0, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sig_a_toggle_gen.md
Name: sig_a_toggle_gen

Overview:
- Synthesizable stimulus source that drives the single-bit `sig_a` consumed by the per-clock change checkers.
- On a `start` request it runs a burst of programmable length, updating `sig_a` once per clock in one of three modes: LFSR random, forced toggle, or hold.
- Reports busy/done status and an optional count of the clocks on which `sig_a` actually changed.
- Sits at bench/top level so checker assertions get deterministic, reproducible stimulus.

Parameters:
- LFSR_W, 16, LFSR width; fixed 16 for the listed polynomial.
- SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero.
- LEN_W, 8, width of `burst_len` and `change_cnt`.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  burst request, sampled only in IDLE.
- mode  in  2  00 random (LFSR), 01 toggle, 10 hold, 11 reserved (behaves as hold).
- burst_len  in  LEN_W  number of generated values, 1..2^LEN_W-1.
- sig_a  out  1  generated signal (registered).
- valid  out  1  high while `sig_a` carries a burst-generated value.
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse in DONE.
- change_cnt  out  LEN_W  number of burst updates where `sig_a` differed from its previous value.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-burst):
  - state=IDLE; sig_a=0, valid=0, busy=0, done=0, change_cnt=0.
  - lfsr=SEED; remaining=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and burst_len!=0: capture mode and burst_len (remaining=burst_len), clear change_cnt, go to RUN.
  - start=1 with burst_len==0: ignored; stay in IDLE, no done.
- RUN:
  - busy=1. At each posedge, sig_a gets the next value per the captured mode, valid<=1, and remaining decrements.
  - When remaining==1 at the edge, go to DONE.
  - start is ignored. Changes on mode/burst_len have no effect until the next acceptance.
- DONE:
  - Lasts one cycle; busy=0, done=1, then IDLE.
  - valid is still 1 during DONE (it carries the last value) and falls at the DONE->IDLE edge.
  - valid is therefore high for exactly burst_len cycles; done coincides with the last valid cycle.
- Random mode:
  - Galois right-shift LFSR: if lfsr[0] then lfsr<=(lfsr>>1)^16'hB400 else lfsr<=lfsr>>1.
  - sig_a<=next_lfsr[0].
  - The LFSR advances only in RUN with mode 00. It is not reloaded between bursts, only on reset.
- Toggle mode: sig_a<=~sig_a on every RUN edge.
- Hold / reserved modes: sig_a unchanged; valid still asserted.
- Outside bursts: sig_a holds its last value; the LFSR is frozen.
- start asserted in the DONE cycle: ignored. A new burst needs start in IDLE, so back-to-back bursts are separated by at least the DONE cycle plus one IDLE cycle.

Optional Feature:
- Macro: SIG_A_CHG_CNT_EN.
- Defined:
  - At each RUN edge, if the new sig_a != the current sig_a, change_cnt increments.
  - Saturates at 2^LEN_W-1.
  - Cleared at start acceptance; holds its value after DONE until the next acceptance.
- Undefined: counter logic omitted; change_cnt tied to 0.

Test Plan:
- Reset, mode=01, burst_len=10, start 1 cycle:
  - busy high 10 cycles; sig_a toggles 1,0,1,… on 10 consecutive edges.
  - valid high 10 cycles; done pulses once with the 10th value.
  - change_cnt=10 (with _EN).
- Reset, mode=00, burst_len=5:
  - sig_a sequence 0,0,0,0,1 (lfsr E270,7138,389C,1C4E,0E27).
  - change_cnt=1.
- mode=10, burst_len=4 after a toggle burst ending sig_a=0:
  - sig_a stays 0; valid high 4 cycles; change_cnt=0.
- start with burst_len=0:
  - no busy, no valid, no done.
  - sig_a and change_cnt unchanged.
- Assert rst low mid-burst (mode 01, burst_len=20, after 7 values):
  - sig_a, valid, busy, done and change_cnt are 0 immediately.
  - After release, a random burst replays the SEED sequence 0,0,0,0,1.
- start pulsed continuously during a 6-value burst:
  - exactly one done.
  - The next burst starts only from IDLE (≥2 cycles after the last valid).
